// File: rtl/temp_pkg.sv
// Types, widths and the word-to-degrees conversion shared by the temperature front end
// and the averager.
package temp_pkg;

  localparam int unsigned TEMP_W     = 9;
  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    UPDATE
  } state_e;

  // The high byte is the signed integer-degree part (floor of the 1/16 degree value).
  // Sign-magnitude is derived from it; zero always comes out as positive zero.
  function automatic logic [TEMP_W-1:0] sm_from_word(input logic [FRAME_BITS-1:0] w);
    logic [7:0] t;
    logic       unused_frac;
    t           = w[FRAME_BITS-1 -: 8];
    unused_frac = ^w[FRAME_BITS-9:0];
    return {t[7], (t[7] ? 8'(-t) : t)};
  endfunction

endpackage

// File: rtl/sclk_divider.sv
// SPI clock generator: counts clk cycles per half period, toggles a registered sclk and
// flags the cycle in which sclk is about to rise or fall. Held idle low while disabled.
module sclk_divider #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            wrap;

  assign wrap = en && (cnt_q == CntW'(CLK_DIV - 1));
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      sclk  <= ~sclk;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodically reads a 16-bit two's-complement word from an SPI (mode 0) temperature sensor
// and presents it as held sign-magnitude integer degrees with a one-cycle update strobe.
module temp_sensor_reader
  import temp_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_n,
  output logic [TEMP_W-1:0] temperatura,
  output logic              sample_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned PerW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);

  state_e                state_q;
  logic [PerW-1:0]       per_q;
  logic                  pending_q;
  logic [DivW-1:0]       div_q;
  logic [BitW-1:0]       bit_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  tick;
  logic                  start;
  logic                  sclk_rise;
  logic                  sclk_fall;

  assign tick = en && (per_q == PerW'(SAMPLE_PERIOD - 1));

  // A frame may begin from IDLE or straight out of UPDATE, which keeps back-to-back
  // frames separated by exactly one cs_n-high cycle.
  assign start = ((state_q == IDLE) || (state_q == UPDATE)) && (tick || (pending_q && en));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_q <= '0;
    end else if (!en || tick) begin
      per_q <= '0;
    end else begin
      per_q <= per_q + 1'b1;
    end
  end

  // Ticks arriving mid-frame collapse into a single pending request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
    end else if (!en || start) begin
      pending_q <= 1'b0;
    end else if (tick) begin
      pending_q <= 1'b1;
    end
  end

  sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_divider (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == SHIFT),
    .sclk (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      cs_n         <= 1'b1;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      temperatura  <= '0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_q)
        IDLE, UPDATE: begin
          if (start) begin
            state_q <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          if (div_q == DivW'(CLK_DIV - 1)) begin
            div_q   <= '0;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], miso};
            bit_q   <= bit_q + 1'b1;
          end
          if (sclk_fall && (bit_q == BitW'(FRAME_BITS))) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (div_q == DivW'(CLK_DIV - 1)) begin
            div_q        <= '0;
            state_q      <= UPDATE;
            cs_n         <= 1'b1;
            busy         <= 1'b0;
            sample_valid <= 1'b1;
            // A frame with non-zero reserved bits is flagged and its value discarded.
            if (shift_q[1:0] != 2'b00) begin
              frame_err <= 1'b1;
            end else begin
              temperatura <= sm_from_word(shift_q);
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Scoreboard bench: instance A (period 200) checks conversion, timing, errors, reset abort
// and enable handling; instance B (period 40) checks pending collapse and back-to-back frames.
module tb_temp_sensor_reader;

  typedef struct {
    logic [8:0] temp;
    logic       err;
    int         gap;
    bit         from_ref;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, rst_b, en_b;
  logic       miso_a, sclk_a, cs_n_a, valid_a, busy_a, err_a;
  logic       miso_b, sclk_b, cs_n_b, valid_b, busy_b, err_b;
  logic [8:0] temp_a, temp_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int last_pulse = 0;
  int pulses_a = 0;
  int n_pushed = 0;
  bit abort_a = 1'b0;

  logic [15:0] words_a[$];
  exp_t        exp_q[$];

  temp_sensor_reader #(
    .CLK_DIV       (2),
    .SAMPLE_PERIOD (200)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .miso         (miso_a),
    .sclk         (sclk_a),
    .cs_n         (cs_n_a),
    .temperatura  (temp_a),
    .sample_valid (valid_a),
    .busy         (busy_a),
    .frame_err    (err_a)
  );

  temp_sensor_reader #(
    .CLK_DIV       (2),
    .SAMPLE_PERIOD (40)
  ) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .en           (en_b),
    .miso         (miso_b),
    .sclk         (sclk_b),
    .cs_n         (cs_n_b),
    .temperatura  (temp_b),
    .sample_valid (valid_b),
    .busy         (busy_b),
    .frame_err    (err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sensor models: load the word when cs_n falls, present the next bit after each sclk fall.
  logic [15:0] sh_a = '0, sh_b = '0;
  logic        s_cs_a = 1'b1, s_sclk_a = 1'b0, s_cs_b = 1'b1, s_sclk_b = 1'b0;
  assign miso_a = sh_a[15];
  assign miso_b = sh_b[15];

  always @(negedge clk) begin
    if (!cs_n_a && s_cs_a) begin
      if (words_a.size() > 0) sh_a <= words_a.pop_front();
      else sh_a <= 16'h0000;
    end else if (!cs_n_a && s_sclk_a && !sclk_a) begin
      sh_a <= sh_a << 1;
    end
    if (!cs_n_b && s_cs_b) sh_b <= 16'h1910;
    else if (!cs_n_b && s_sclk_b && !sclk_b) sh_b <= sh_b << 1;
    s_cs_a   <= cs_n_a;
    s_sclk_a <= sclk_a;
    s_cs_b   <= cs_n_b;
    s_sclk_b <= sclk_b;
  end

  // Scoreboard monitor for A.
  exp_t mon_e;
  int   mon_gap;
  always @(negedge clk) begin
    if (valid_a) begin
      pulses_a++;
      if (exp_q.size() == 0) begin
        check("pulse_without_expectation", exp_q.size(), 1);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_gap = mon_e.from_ref ? (cyc - ref_cyc) : (cyc - last_pulse);
        check("temperatura", int'(temp_a), int'(mon_e.temp));
        check("frame_err", int'(err_a), int'(mon_e.err));
        check("pulse_spacing", mon_gap, mon_e.gap);
      end
      last_pulse = cyc;
    end
  end

  // Frame-shape monitor for A: cs_n low time and sclk rising edges per completed frame.
  int   low_a = 0, rises_a = 0;
  logic f_cs_a = 1'b1, f_sclk_a = 1'b0;
  always @(negedge clk) begin
    if (!cs_n_a) begin
      low_a++;
      if (sclk_a && !f_sclk_a) rises_a++;
    end else if (!f_cs_a) begin
      if (!abort_a) begin
        check("cs_n_low_cycles", low_a, 68);
        check("sclk_rises", rises_a, 16);
      end
      low_a   = 0;
      rises_a = 0;
    end
    f_cs_a   = cs_n_a;
    f_sclk_a = sclk_a;
  end

  // Monitor for B: every frame reads 0x1910, frames run back to back 69 cycles apart.
  int   pulses_b = 0, frames_b = 0, high_b = 0, last_b = 0;
  logic f_cs_b = 1'b1;
  always @(negedge clk) begin
    if (valid_b) begin
      if (pulses_b > 0) check("b_pulse_spacing", cyc - last_b, 69);
      check("b_temperatura", int'(temp_b), 'h019);
      pulses_b++;
      last_b = cyc;
    end
    if (cs_n_b) begin
      high_b++;
    end else if (f_cs_b) begin
      if (frames_b > 0) check("b_cs_n_high_gap", high_b, 1);
      frames_b++;
      high_b = 0;
    end
    f_cs_b = cs_n_b;
  end

  task automatic push(input logic [15:0] w, input logic [8:0] t, input logic er,
                      input int gap, input bit from_ref);
    exp_t e;
    e.temp     = t;
    e.err      = er;
    e.gap      = gap;
    e.from_ref = from_ref;
    words_a.push_back(w);
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("busy_wait", int'(busy_a), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, rises, base;
    logic prev;
    rst = 1'b0; rst_b = 1'b0; en = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", int'(cs_n_a), 1);
    check("rst_sclk", int'(sclk_a), 0);
    check("rst_temperatura", int'(temp_a), 0);
    check("rst_sample_valid", int'(valid_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_frame_err", int'(err_a), 0);
    @(negedge clk);
    rst = 1'b1; rst_b = 1'b1;

    // First frame lands 200 + 68 cycles after enable, then one per 200 cycles.
    push(16'h1910, 9'h019, 1'b0, 268, 1'b1);
    push(16'hE700, 9'h119, 1'b0, 200, 1'b0);
    push(16'hFF80, 9'h101, 1'b0, 200, 1'b0);
    push(16'h8000, 9'h180, 1'b0, 200, 1'b0);
    push(16'h0000, 9'h000, 1'b0, 200, 1'b0);
    push(16'h2A00, 9'h02A, 1'b0, 200, 1'b0);
    push(16'h1913, 9'h02A, 1'b1, 200, 1'b0);
    push(16'h0A00, 9'h00A, 1'b1, 200, 1'b0);
    @(negedge clk);
    ref_cyc = cyc;
    en = 1'b1;
    wait_drain(2200);
    en = 1'b0;

    // Reset at the 7th sclk rise of a frame.
    repeat (10) @(negedge clk);
    words_a.push_back(16'h7F00);
    en = 1'b1;
    wait_busy();
    n = 0; rises = 0; prev = sclk_a;
    while (rises < 7 && n < 400) begin
      @(negedge clk);
      n++;
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
    end
    check("rises_before_abort", rises, 7);
    abort_a = 1'b1;
    rst = 1'b0;
    #1;
    check("abort_cs_n", int'(cs_n_a), 1);
    check("abort_sclk", int'(sclk_a), 0);
    check("abort_busy", int'(busy_a), 0);
    check("abort_temperatura", int'(temp_a), 0);
    check("abort_frame_err", int'(err_a), 0);
    @(negedge clk);
    rst = 1'b1;
    ref_cyc = cyc;
    push(16'h1910, 9'h019, 1'b0, 268, 1'b1);
    wait_drain(600);
    en = 1'b0;
    abort_a = 1'b0;

    // Enable dropped mid-frame: the frame finishes, nothing follows until re-enable.
    repeat (10) @(negedge clk);
    ref_cyc = cyc;
    en = 1'b1;
    push(16'h3200, 9'h032, 1'b0, 268, 1'b1);
    wait_busy();
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_drain(300);
    base = pulses_a;
    repeat (500) @(negedge clk);
    check("no_frame_after_en_drop", pulses_a - base, 0);
    check("idle_cs_n_after_en_drop", int'(cs_n_a), 1);
    ref_cyc = cyc;
    en = 1'b1;
    push(16'hF000, 9'h110, 1'b0, 268, 1'b1);
    wait_drain(600);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("a_pulse_count", pulses_a, n_pushed);

    // Instance B: 780 enabled cycles start 11 back-to-back frames (first tick at +39).
    en_b = 1'b1;
    repeat (780) @(negedge clk);
    en_b = 1'b0;
    repeat (200) @(negedge clk);
    check("b_pulse_count", pulses_b, 11);
    check("b_frame_count", frames_b, 11);
    check("b_busy_idle", int'(busy_b), 0);
    check("b_frame_err", int'(err_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
